// File: rtl/inst_cache_pkg.sv
// Shared types and helpers for the direct-mapped instruction cache.
// Index/tag helpers return full-width values; callers size-cast to their field widths.
package inst_cache_pkg;

  localparam int INST_WIDTH = 32;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  function automatic logic [31:0] line_index(input logic [31:0] addr, input int unsigned index_bits);
    return (addr >> 2) & ((32'd1 << index_bits) - 32'd1);
  endfunction

  function automatic logic [31:0] line_tag(input logic [31:0] addr, input int unsigned index_bits);
    return addr >> (2 + index_bits);
  endfunction

endpackage

// File: rtl/inst_cache_array.sv
// Valid/tag/data storage: async read port, one synchronous write port.
// Only the valid bits are reset; tag and data are qualified by valid.
module inst_cache_array
  import inst_cache_pkg::*;
#(
  parameter int INDEX_BITS = 6,
  parameter int TAG_W      = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_BITS-1:0] rd_idx,
  output logic                  rd_valid,
  output logic [TAG_W-1:0]      rd_tag,
  output logic [INST_WIDTH-1:0] rd_data,
  input  logic                  wr_en,
  input  logic [INDEX_BITS-1:0] wr_idx,
  input  logic [TAG_W-1:0]      wr_tag,
  input  logic [INST_WIDTH-1:0] wr_data
);

  localparam int LINES = 2 ** INDEX_BITS;

  logic [LINES-1:0]      valid_q;
  logic [TAG_W-1:0]      tag_q  [LINES];
  logic [INST_WIDTH-1:0] data_q [LINES];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_data  = data_q[rd_idx];

endmodule

// File: rtl/inst_cache.sv
// Direct-mapped instruction cache: combinational hit path, single outstanding miss,
// same-cycle bypass of the returning fill. rdy=0 freezes every register.
module inst_cache
  import inst_cache_pkg::*;
#(
  parameter int INDEX_BITS = 6,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_pc,
  output logic                  if_hit,
  output logic [INST_WIDTH-1:0] if_ins,
  output logic                  mc_req,
  output logic [ADDR_WIDTH-1:0] mc_addr,
  input  logic [INST_WIDTH-1:0] mc_ins,
  input  logic                  mc_ins_rdy,
  output state_t                fsm_state
);

  localparam int TAG_W = ADDR_WIDTH - 2 - INDEX_BITS;

  state_t state, next_state;

  logic [INDEX_BITS-1:0] pc_idx, fill_idx;
  logic [TAG_W-1:0]      pc_tag, fill_tag, rd_tag;
  logic                  rd_valid;
  logic [INST_WIDTH-1:0] rd_data;
  logic                  lookup_hit;
  logic                  issue, fill, bypass;

  assign pc_idx   = INDEX_BITS'(line_index(32'(if_pc), INDEX_BITS));
  assign pc_tag   = TAG_W'(line_tag(32'(if_pc), INDEX_BITS));
  assign fill_idx = INDEX_BITS'(line_index(32'(mc_addr), INDEX_BITS));
  assign fill_tag = TAG_W'(line_tag(32'(mc_addr), INDEX_BITS));

  inst_cache_array #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_W      (TAG_W)
  ) u_array (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (pc_idx),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (fill),
    .wr_idx   (fill_idx),
    .wr_tag   (fill_tag),
    .wr_data  (mc_ins)
  );

  assign lookup_hit = if_req && rd_valid && (rd_tag == pc_tag);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else if (rdy) begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (if_req && !lookup_hit) next_state = WAIT;
      WAIT: if (mc_ins_rdy) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Fill and bypass are qualified by rdy so a held mc_ins_rdy is ignored during a stall.
  always_comb begin
    issue  = 1'b0;
    fill   = 1'b0;
    bypass = 1'b0;
    case (state)
      IDLE: issue = rdy && if_req && !lookup_hit;
      WAIT: begin
        fill   = rdy && mc_ins_rdy;
        bypass = rdy && mc_ins_rdy && if_req
                 && (if_pc[ADDR_WIDTH-1:2] == mc_addr[ADDR_WIDTH-1:2]);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mc_req  <= 1'b0;
      mc_addr <= '0;
    end else if (rdy) begin
      mc_req <= issue;
      if (issue) mc_addr <= {if_pc[ADDR_WIDTH-1:2], 2'b00};
    end
  end

  assign if_hit    = lookup_hit || bypass;
  assign if_ins    = bypass ? mc_ins : rd_data;
  assign fsm_state = state;

endmodule

// File: tb/tb_inst_cache.sv
// Directed bench for inst_cache: cold miss, hits, conflicts, hit-under-miss,
// rdy stall and reset mid-miss, with a small request-pulse monitor.
module tb_inst_cache;
  import inst_cache_pkg::*;

  logic        clk = 1'b0;
  logic        rst, rdy, if_req, if_hit, mc_req, mc_ins_rdy;
  logic [31:0] if_pc, if_ins, mc_addr, mc_ins;
  state_t      fsm_state;

  int errors = 0;
  int checks = 0;
  int req_pulses = 0;
  int pulses_before;

  inst_cache #(.INDEX_BITS(6), .ADDR_WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .rdy        (rdy),
    .if_req     (if_req),
    .if_pc      (if_pc),
    .if_hit     (if_hit),
    .if_ins     (if_ins),
    .mc_req     (mc_req),
    .mc_addr    (mc_addr),
    .mc_ins     (mc_ins),
    .mc_ins_rdy (mc_ins_rdy),
    .fsm_state  (fsm_state)
  );

  always #5 clk = ~clk;

  // Request pulses as the controller sees them: mc_req high at an enabled edge.
  always @(posedge clk) begin
    if (!rst && rdy && mc_req) req_pulses++;
  end

  // The controller must only answer while a miss is outstanding.
  always @(negedge clk) begin
    if (!rst && rdy && mc_ins_rdy) begin
      checks++;
      assert (fsm_state === WAIT) else begin
        errors++;
        $error("FAIL proto_ins_rdy_in_idle: observed=%0d expected=%0d", fsm_state, WAIT);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_pc(input logic [31:0] pc);
    if_req = 1'b1;
    if_pc  = pc;
    #1;
  endtask

  // Full miss on pc: one request, 5 idle wait cycles, then fill with bypass.
  task automatic do_miss(input string tag, input logic [31:0] pc, input logic [31:0] ins);
    int p0;
    set_pc(pc);
    check({tag, "_miss"}, {31'b0, if_hit}, 32'd0);
    p0 = req_pulses;
    step();
    check({tag, "_req"}, {31'b0, mc_req}, 32'd1);
    check({tag, "_addr"}, mc_addr, pc & 32'hFFFF_FFFC);
    step(5);
    check({tag, "_req_once"}, 32'(req_pulses - p0), 32'd1);
    mc_ins_rdy = 1'b1;
    mc_ins     = ins;
    #1;
    check({tag, "_bypass_hit"}, {31'b0, if_hit}, 32'd1);
    check({tag, "_bypass_ins"}, if_ins, ins);
    step();
    mc_ins_rdy = 1'b0;
    mc_ins     = 32'h0;
    #1;
    check({tag, "_idle"}, {31'b0, fsm_state}, {31'b0, IDLE});
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; if_req = 1'b0; if_pc = 32'h0;
    mc_ins = 32'h0; mc_ins_rdy = 1'b0;
    step(2);
    rst = 1'b0;
    #1;
    check("reset_mc_req", {31'b0, mc_req}, 32'd0);
    check("reset_mc_addr", mc_addr, 32'h0);
    check("reset_state", {31'b0, fsm_state}, {31'b0, IDLE});
    set_pc(32'h0000_1004);
    check("reset_no_hit", {31'b0, if_hit}, 32'd0);
    if_req = 1'b0;

    // Cold miss with bypass, then a plain hit with no new request.
    do_miss("cold", 32'h0000_1004, 32'h0000_0013);
    pulses_before = req_pulses;
    set_pc(32'h0000_1004);
    check("hit_after_fill", {31'b0, if_hit}, 32'd1);
    check("hit_after_fill_ins", if_ins, 32'h0000_0013);
    step(2);
    check("hit_no_req", 32'(req_pulses - pulses_before), 32'd0);

    // Conflict at index 1: 0x1104 evicts 0x1004, which then misses again.
    do_miss("conflict", 32'h0000_1104, 32'hAAAA_0001);
    set_pc(32'h0000_1004);
    check("evicted_miss", {31'b0, if_hit}, 32'd0);
    if_req = 1'b0;
    #1;
    set_pc(32'h0000_1104);
    check("conflict_hit_ins", if_ins, 32'hAAAA_0001);
    do_miss("refill", 32'h0000_1004, 32'h0000_0013);

    // Hit-under-miss and wrong-path completion.
    set_pc(32'h0000_2000);
    pulses_before = req_pulses;
    step();
    check("hum_req", {31'b0, mc_req}, 32'd1);
    set_pc(32'h0000_1004);
    check("hum_hit", {31'b0, if_hit}, 32'd1);
    check("hum_hit_ins", if_ins, 32'h0000_0013);
    set_pc(32'h0000_3000);
    check("hum_other_miss", {31'b0, if_hit}, 32'd0);
    step(4);
    check("hum_single_req", 32'(req_pulses - pulses_before), 32'd1);
    mc_ins_rdy = 1'b1;
    mc_ins     = 32'hBEEF_2000;
    #1;
    check("wrongpath_no_bypass", {31'b0, if_hit}, 32'd0);
    step();
    mc_ins_rdy = 1'b0;
    #1;
    check("wrongpath_no_issue_in_fill", 32'(req_pulses - pulses_before), 32'd1);
    step();
    check("next_miss_req", {31'b0, mc_req}, 32'd1);
    check("next_miss_addr", mc_addr, 32'h0000_3000);
    set_pc(32'h0000_2000);
    check("wrongpath_installed", {31'b0, if_hit}, 32'd1);
    check("wrongpath_ins", if_ins, 32'hBEEF_2000);
    step(5);
    set_pc(32'h0000_3000);
    mc_ins_rdy = 1'b1;
    mc_ins     = 32'h0000_3333;
    #1;
    check("fill_3000_bypass", if_ins, 32'h0000_3333);
    step();
    mc_ins_rdy = 1'b0;
    #1;

    // rdy stall: request held while frozen, counted once; held ins_rdy ignored.
    set_pc(32'h0000_4000);
    pulses_before = req_pulses;
    step();
    rdy = 1'b0;
    step(2);
    check("stall_req_frozen", {31'b0, mc_req}, 32'd1);
    rdy = 1'b1;
    step();
    check("stall_req_dropped", {31'b0, mc_req}, 32'd0);
    check("stall_req_once", 32'(req_pulses - pulses_before), 32'd1);
    step(4);
    mc_ins_rdy = 1'b1;
    mc_ins     = 32'h0000_0055;
    rdy        = 1'b0;
    #1;
    check("stall_no_bypass", {31'b0, if_hit}, 32'd0);
    step(3);
    check("stall_still_wait", {31'b0, fsm_state}, {31'b0, WAIT});
    rdy = 1'b1;
    #1;
    check("stall_release_bypass", if_ins, 32'h0000_0055);
    step();
    mc_ins_rdy = 1'b0;
    #1;
    check("stall_filled_idle", {31'b0, fsm_state}, {31'b0, IDLE});
    check("stall_filled_hit", {31'b0, if_hit}, 32'd1);

    // Reset mid-miss.
    set_pc(32'h0000_5000);
    step();
    check("rstmid_wait", {31'b0, fsm_state}, {31'b0, WAIT});
    rst = 1'b1;
    if_req = 1'b0;
    step();
    rst = 1'b0;
    #1;
    check("rstmid_mc_req", {31'b0, mc_req}, 32'd0);
    check("rstmid_state", {31'b0, fsm_state}, {31'b0, IDLE});
    set_pc(32'h0000_1004);
    check("rstmid_resident_miss", {31'b0, if_hit}, 32'd0);
    step();
    check("rstmid_new_req", {31'b0, mc_req}, 32'd1);
    check("rstmid_new_addr", mc_addr, 32'h0000_1004);
    if_req = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
